instruction_fetch: RTL and testbench

- Fetch stage directly upstream of instruction decode.
- Holds the program counter and issues word-aligned read requests to the instruction memory bus.
- Accepts in-order read responses into a small buffer and presents {instruction, pc} to decode over a valid/ready handshake.
- Handles control-flow redirects from execute: discards stale in-flight responses, then restarts fetch at the target.

---
 rtl/instruction_fetch.sv | 125 ++++++++++++
 tb/tb_instruction_fetch.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, credit-limited instruction fetch with redirect flush.
// Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_im_req_valid,
  input  logic            i_im_req_ready,
  output logic [XLEN-1:0] o_im_addr,
  input  logic            i_im_rvalid,
  input  logic [XLEN-1:0] i_im_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_if_valid,
  input  logic            i_if_ready,
  output logic [XLEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            o_misalign
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding, drop_cnt, buf_count;
  logic [PW-1:0]   tag_wr, tag_rd, buf_wr, buf_rd;
  logic [XLEN-1:0] tag_q     [DEPTH];
  logic [XLEN-1:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc    [DEPTH];
  logic [CW:0]     in_use;
  logic            halt, accept, push, pop;
  logic [XLEN-1:0] target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign halt   = o_misalign;
  assign target = i_redirect_pc;
`else
  assign halt   = 1'b0;
  assign target = i_redirect_pc & ~XLEN'(3);
`endif

  // Credit covers every in-flight response, so responses never need backpressure.
  assign in_use         = {1'b0, outstanding} + {1'b0, buf_count};
  assign o_im_req_valid = rstn && !i_redirect_valid && !halt && (in_use < (CW+1)'(DEPTH));
  assign o_im_addr      = pc;
  assign accept         = o_im_req_valid && i_im_req_ready;
  assign push           = i_im_rvalid && !i_redirect_valid && (drop_cnt == '0);
  assign o_if_valid     = (buf_count != '0);
  assign pop            = o_if_valid && i_if_ready;
  assign o_if_instr     = o_if_valid ? buf_instr[buf_rd] : '0;
  assign o_if_pc        = o_if_valid ? buf_pc[buf_rd]    : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      buf_count   <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      o_misalign  <= 1'b0;
`endif
    end else begin
      if (i_redirect_valid)
        pc <= target;
      else if (accept)
        pc <= pc + XLEN'(4);
`ifdef FETCH_MISALIGN_TRAP_EN
      if (i_redirect_valid)
        o_misalign <= (i_redirect_pc[1:0] != 2'b00);
`endif
      if (accept)
        tag_wr <= tag_wr + PW'(1);
      if (i_im_rvalid)
        tag_rd <= tag_rd + PW'(1);

      case ({accept, i_im_rvalid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      // Responses still owed for pre-redirect requests are discarded as they return.
      if (i_redirect_valid)
        drop_cnt <= outstanding - CW'(i_im_rvalid);
      else if (i_im_rvalid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);

      if (i_redirect_valid) begin
        buf_wr    <= '0;
        buf_rd    <= '0;
        buf_count <= '0;
      end else begin
        if (push)
          buf_wr <= buf_wr + PW'(1);
        if (pop)
          buf_rd <= buf_rd + PW'(1);
        case ({push, pop})
          2'b10:   buf_count <= buf_count + CW'(1);
          2'b01:   buf_count <= buf_count - CW'(1);
          default: buf_count <= buf_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      tag_q[tag_wr] <= pc;
    if (push) begin
      buf_instr[buf_wr] <= i_im_rdata;
      buf_pc[buf_wr]    <= tag_q[tag_rd];
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized bench for instruction_fetch with a queue-based fetch model.
// Honours FETCH_MISALIGN_TRAP_EN.
module tb_instruction_fetch;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] KEY   = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        o_im_req_valid;
  logic        i_im_req_ready = 1'b0;
  logic [31:0] o_im_addr;
  logic        i_im_rvalid = 1'b0;
  logic [31:0] i_im_rdata = '0;
  logic        i_redirect_valid = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_if_valid;
  logic        i_if_ready = 1'b0;
  logic [31:0] o_if_instr;
  logic [31:0] o_if_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        o_misalign;
`endif

  instruction_fetch #(.XLEN(XLEN), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .o_im_req_valid(o_im_req_valid), .i_im_req_ready(i_im_req_ready), .o_im_addr(o_im_addr),
    .i_im_rvalid(i_im_rvalid), .i_im_rdata(i_im_rdata),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_if_valid(o_if_valid), .i_if_ready(i_if_ready), .o_if_instr(o_if_instr), .o_if_pc(o_if_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .o_misalign(o_misalign)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;
  int n_deliv = 0;
  bit sb_en = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];

  // Reference fetch model: in-flight count, expected buffer of pcs, stale responses owed.
  int          m_inflight = 0;
  int          m_drop = 0;
  logic [31:0] m_buf[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_halt = 0;

  // Memory: in-order responses, each no earlier than its latency after acceptance.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      i_im_rvalid = 1'b1;
      i_im_rdata  = mem_q[0].addr ^ KEY;
    end else begin
      i_im_rvalid = 1'b0;
      i_im_rdata  = $urandom;
    end
  end

  always @(negedge clk) begin : scoreboard
    bit          exp_rv, acc, hs;
    logic [31:0] rpc;
    mreq_t       r;
    if (sb_en) begin
      exp_rv = rstn && !i_redirect_valid && !m_halt && (m_inflight + m_buf.size() < DEPTH);
      checks++;
      if (o_im_req_valid !== exp_rv) begin
        failures++;
        $display("FAIL req_valid got=%b exp=%b t=%0t", o_im_req_valid, exp_rv, $time);
      end
      if (exp_rv) begin
        checks++;
        if (o_im_addr !== m_pc) begin
          failures++;
          $display("FAIL im_addr got=%h exp=%h t=%0t", o_im_addr, m_pc, $time);
        end
      end
      checks++;
      if (o_if_valid !== (m_buf.size() > 0)) begin
        failures++;
        $display("FAIL if_valid got=%b exp=%b t=%0t", o_if_valid, (m_buf.size() > 0), $time);
      end
      if (m_buf.size() > 0) begin
        checks++;
        if (o_if_pc !== m_buf[0] || o_if_instr !== (m_buf[0] ^ KEY)) begin
          failures++;
          $display("FAIL if_entry got=%h/%h exp=%h/%h t=%0t", o_if_pc, o_if_instr, m_buf[0], m_buf[0] ^ KEY, $time);
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      checks++;
      if (o_misalign !== m_halt) begin
        failures++;
        $display("FAIL misalign got=%b exp=%b t=%0t", o_misalign, m_halt, $time);
      end
`endif
      if (!rstn) begin
        m_inflight = 0; m_drop = 0; m_buf.delete(); m_pc = 32'h0; m_halt = 0;
        mem_q.delete(); last_due = 0;
      end else begin
        acc = exp_rv && i_im_req_ready;
        hs  = (m_buf.size() > 0) && i_if_ready;
        rpc = '0;
        if (i_im_rvalid && mem_q.size() > 0) begin
          rpc = mem_q[0].addr;
          void'(mem_q.pop_front());
        end
        if (acc) begin
          r.addr = m_pc;
          r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          last_due = r.due;
          mem_q.push_back(r);
        end
        if (i_redirect_valid) begin
          m_drop = m_inflight - int'(i_im_rvalid);
          m_inflight = m_inflight - int'(i_im_rvalid);
          m_buf.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
          m_pc = i_redirect_pc;
          m_halt = (i_redirect_pc[1:0] != 2'b00);
`else
          m_pc = {i_redirect_pc[31:2], 2'b00};
`endif
        end else begin
          if (hs) begin
            void'(m_buf.pop_front());
            n_deliv++;
          end
          if (i_im_rvalid) begin
            if (m_drop > 0) m_drop--;
            else m_buf.push_back(rpc);
          end
          if (acc) m_pc = m_pc + 32'd4;
          m_inflight = m_inflight + int'(acc) - int'(i_im_rvalid);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_redirect_valid = 1'b0; i_im_req_ready = 1'b1; i_if_ready = 1'b1; lat = 1;
    tick();
    sb_en = 1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (o_im_req_valid !== 1'b0 || o_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids got=%b%b exp=00", o_im_req_valid, o_if_valid);
    end
    checks++;
    if (o_if_instr !== 32'h0 || o_if_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%h exp=0/0", o_if_instr, o_if_pc);
    end
    checks++;
    if (o_im_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc got=%h exp=0", o_im_addr);
    end
  endtask

  task automatic test_stream();
    int          first = -1;
    int          n = 0;
    logic [31:0] exp_pc = 32'h0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_if_valid) begin
        first = k;
        break;
      end
      tick();
    end
    checks++;
    if (first != 2) begin
      failures++;
      $display("FAIL startup_latency got=%0d exp=2", first);
    end
    for (int i = 0; i < 30 && n < 6; i++) begin
      if (o_if_valid) begin
        checks++;
        if (o_if_pc !== exp_pc || o_if_instr !== (exp_pc ^ KEY)) begin
          failures++;
          $display("FAIL stream_pc got=%h exp=%h", o_if_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        n++;
      end
      tick();
      @(negedge clk);
    end
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=6", n);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held = '0;
    tick();
    i_if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (i == 2) held = o_if_pc;
      if (i >= 3) begin
        checks++;
        if (o_if_valid !== 1'b1 || o_im_req_valid !== 1'b0 || o_if_pc !== held) begin
          failures++;
          $display("FAIL stall_hold got=%b%b/%h exp=10/%h", o_if_valid, o_im_req_valid, o_if_pc, held);
        end
      end
    end
    tick();
    i_if_ready = 1'b1;
    repeat (10) tick();
  endtask

  task automatic wait_pc(input logic [31:0] exp_pc, input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_if_valid) begin
        seen = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || o_if_pc !== exp_pc) begin
      failures++;
      $display("FAIL %s got=%h valid=%b exp=%h", name, o_if_pc, seen, exp_pc);
    end
  endtask

  task automatic test_redirect();
    bit found = 0;
    tick();
    lat = 3;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m_inflight == 2) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL redirect_setup got=%0d exp=2", m_inflight);
    end
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h100;
    tick();
    i_redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_flush got=%b exp=0", o_if_valid);
    end
    wait_pc(32'h100, "redirect_target");
    tick();
    wait_pc(32'h104, "redirect_next");
  endtask

  task automatic test_redirect_collide();
    bit found = 0;
    tick();
    lat = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i_im_rvalid && o_if_valid) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL collide_setup got=0 exp=1");
    end
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h200;
    tick();
    i_redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_if_valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_flush got=%b exp=0", o_if_valid);
    end
    wait_pc(32'h200, "collide_target");
  endtask

  task automatic test_misalign();
    tick();
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h102;
    tick();
    i_redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_misalign !== 1'b1 || o_im_req_valid !== 1'b0 || o_im_addr !== 32'h102) begin
        failures++;
        $display("FAIL misalign_halt got=%b%b/%h exp=10/102", o_misalign, o_im_req_valid, o_im_addr);
      end
      tick();
    end
    i_redirect_valid = 1'b1; i_redirect_pc = 32'h300;
    tick();
    i_redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_misalign !== 1'b0) begin
      failures++;
      $display("FAIL misalign_clear got=%b exp=0", o_misalign);
    end
    wait_pc(32'h300, "misalign_resume");
`else
    wait_pc(32'h100, "misalign_forced");
`endif
  endtask

  task automatic test_wrap();
    logic [31:0] got[3];
    int          n = 0;
    tick();
    i_redirect_valid = 1'b1; i_redirect_pc = 32'hFFFF_FFF8;
    tick();
    i_redirect_valid = 1'b0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (o_if_valid) begin
        got[n] = o_if_pc;
        n++;
      end
      tick();
    end
    checks++;
    if (n != 3 || got[2] !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap got=%h n=%0d exp=00000000", got[2], n);
    end
  endtask

  task automatic test_random();
    int start;
    tick();
    start = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      i_im_req_ready   = ($urandom_range(0, 3) != 0);
      i_if_ready       = ($urandom_range(0, 3) != 0);
      lat              = $urandom_range(1, 4);
      i_redirect_valid = ($urandom_range(0, 29) == 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      i_redirect_pc    = $urandom & 32'hFFFF_FFFC;
`else
      i_redirect_pc    = $urandom;
`endif
      rstn             = (i != 1500);
      tick();
    end
    rstn = 1'b1; i_redirect_valid = 1'b0; i_if_ready = 1'b1; i_im_req_ready = 1'b1;
    repeat (10) tick();
    checks++;
    if (n_deliv - start < 200) begin
      failures++;
      $display("FAIL random_progress got=%0d exp>=200", n_deliv - start);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_misalign();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
